// File: rtl/segment_scan_decoder_pkg.sv
// Shared definitions for the multiplexed seven-segment score decoder.
//   - scan FSM state encoding
//   - seven-segment patterns (gfedcba, active-high) for 0-9 and blank
//   - pattern and BCD widths, digit-select codes
package segment_scan_decoder_pkg;

  localparam int SEG_W = 7;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_CAPTURED = 2'd2
  } scan_state_e;

  localparam logic [SEG_W-1:0] SEG_PAT_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_PAT_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_PAT_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_PAT_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_PAT_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_PAT_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_PAT_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_PAT_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_PAT_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_PAT_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_PAT_BLANK = 7'h00;

  localparam logic [1:0] SEL_ONES = 2'b01;
  localparam logic [1:0] SEL_TENS = 2'b10;

endpackage

// File: rtl/segment_scan_decoder_seg7_to_bcd.sv
// seg7_to_bcd: combinational seven-segment pattern decoder.
// Ports:
//   i_pattern  in  7  normalised pattern, bit0=a .. bit6=g, 1 = lit
//   o_value    out 4  BCD value (0 when blank or illegal)
//   o_blank    out 1  pattern is all segments off
//   o_legal    out 1  pattern is a digit 0-9 or blank
module seg7_to_bcd
  import segment_scan_decoder_pkg::*;
(
  input  logic [SEG_W-1:0] i_pattern,
  output logic [BCD_W-1:0] o_value,
  output logic             o_blank,
  output logic             o_legal
);

  always_comb begin
    o_value = '0;
    o_blank = 1'b0;
    o_legal = 1'b1;
    case (i_pattern)
      SEG_PAT_0:     o_value = 4'd0;
      SEG_PAT_1:     o_value = 4'd1;
      SEG_PAT_2:     o_value = 4'd2;
      SEG_PAT_3:     o_value = 4'd3;
      SEG_PAT_4:     o_value = 4'd4;
      SEG_PAT_5:     o_value = 4'd5;
      SEG_PAT_6:     o_value = 4'd6;
      SEG_PAT_7:     o_value = 4'd7;
      SEG_PAT_8:     o_value = 4'd8;
      SEG_PAT_9:     o_value = 4'd9;
      SEG_PAT_BLANK: o_blank = 1'b1;
      default:       o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_scan_decoder.sv
// segment_scan_decoder: recovers a two-digit score from a multiplexed
// seven-segment display bus (ones/tens digit strobes).
//   - one input register stage normalises polarity
//   - scan FSM waits for SETTLE_CYCLES identical cycles before latching a digit
//   - a frame (both digits latched) is decoded and committed one cycle later
//   - TIMEOUT_CYCLES with no digit strobed invalidates the score
// Optional build macro SEG_FRAME_CONFIRM_EN: a frame commits only when it
// matches the previous complete frame (two-frame confirmation).
// Ports:
//   clk, rst_n         clock, async active-low reset
//   segments[6:0]      segment drive, bit0=a .. bit6=g
//   segment_digits[1:0] digit strobe, bit0=ones, bit1=tens
//   segments_invert    1 = segments are active-low
//   score_valid        outputs hold a decoded frame
//   score_tens/ones    BCD digits
//   tens_blank         committed tens digit was blank
//   score_update       1-cycle pulse when the committed value changes
//   decode_error       1-cycle pulse on an illegal frame
module segment_scan_decoder
  import segment_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEG_W-1:0] segments,
  input  logic [1:0]       segment_digits,
  input  logic             segments_invert,
  output logic             score_valid,
  output logic [BCD_W-1:0] score_tens,
  output logic [BCD_W-1:0] score_ones,
  output logic             tens_blank,
  output logic             score_update,
  output logic             decode_error
);

  localparam logic [7:0]  SETTLE_N  = 8'(SETTLE_CYCLES);
  localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT_CYCLES);

  // input stage and its one-cycle history for stability detection
  logic [SEG_W-1:0] r_pat, r_pat_d;
  logic [1:0]       r_sel, r_sel_d;

  scan_state_e r_state, w_state_nxt;
  logic [7:0]  r_settle, w_settle_nxt, w_run;
  logic [15:0] r_idle;
  logic        w_onehot, w_same, w_sel_chg, w_settled, w_cap;
  logic        w_cap_ones, w_cap_tens, w_timeout, w_frame;

  logic [SEG_W-1:0] r_ones_pat, r_tens_pat;
  logic             r_ones_cap, r_tens_cap;

  logic [BCD_W-1:0] w_o_val, w_t_val;
  logic             w_o_blank, w_t_blank, w_o_legal, w_t_legal;
  logic             w_frame_err, w_both_blank, w_commit, w_changed;
  logic             w_nxt_valid, w_nxt_tb;
  logic [BCD_W-1:0] w_nxt_tens, w_nxt_ones;

  logic             r_score_valid, r_tens_blank, r_score_update, r_decode_error;
  logic [BCD_W-1:0] r_score_tens, r_score_ones;

  assign score_valid  = r_score_valid;
  assign score_tens   = r_score_tens;
  assign score_ones   = r_score_ones;
  assign tens_blank   = r_tens_blank;
  assign score_update = r_score_update;
  assign decode_error = r_decode_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat   <= '0;
      r_sel   <= '0;
      r_pat_d <= '0;
      r_sel_d <= '0;
    end else begin
      r_pat   <= segments ^ {SEG_W{segments_invert}};
      r_sel   <= segment_digits;
      r_pat_d <= r_pat;
      r_sel_d <= r_sel;
    end
  end

  assign w_onehot  = (r_sel == SEL_ONES) || (r_sel == SEL_TENS);
  assign w_same    = (r_sel == r_sel_d) && (r_pat == r_pat_d);
  assign w_sel_chg = (r_sel != r_sel_d);
  // length of the current run of identical cycles, counting this one
  assign w_run     = (r_state == ST_SETTLE && w_same) ? r_settle + 8'd1 : 8'd1;
  assign w_settled = (w_run >= SETTLE_N);

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_cap        = 1'b0;
    case (r_state)
      ST_IDLE, ST_SETTLE: begin
        if (!w_onehot) begin
          w_state_nxt  = ST_IDLE;
          w_settle_nxt = '0;
        end else if (w_settled) begin
          w_cap        = 1'b1;
          w_state_nxt  = ST_CAPTURED;
          w_settle_nxt = '0;
        end else begin
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = w_run;
        end
      end
      ST_CAPTURED: begin
        // same strobe keeps the latched digit; only a strobe change re-arms
        if (!w_onehot) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sel_chg) begin
          if (w_settled) begin
            w_cap = 1'b1;
          end else begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = w_run;
          end
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_settle_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_settle <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  assign w_cap_ones = w_cap && (r_sel == SEL_ONES);
  assign w_cap_tens = w_cap && (r_sel == SEL_TENS);
  assign w_frame    = r_ones_cap && r_tens_cap;
  // fires once, on the cycle the idle count reaches the limit; a capture
  // needs a one-hot strobe, so the two never coincide
  assign w_timeout  = !w_onehot && (r_idle == TIMEOUT_N - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (w_onehot) begin
      r_idle <= '0;
    end else if (r_idle != TIMEOUT_N) begin
      r_idle <= r_idle + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones_pat <= '0;
      r_tens_pat <= '0;
      r_ones_cap <= 1'b0;
      r_tens_cap <= 1'b0;
    end else begin
      if (w_cap_ones) r_ones_pat <= r_pat;
      if (w_cap_tens) r_tens_pat <= r_pat;
      r_ones_cap <= ((w_frame || w_timeout) ? 1'b0 : r_ones_cap) | w_cap_ones;
      r_tens_cap <= ((w_frame || w_timeout) ? 1'b0 : r_tens_cap) | w_cap_tens;
    end
  end

  seg7_to_bcd u_ones_dec (
    .i_pattern (r_ones_pat),
    .o_value   (w_o_val),
    .o_blank   (w_o_blank),
    .o_legal   (w_o_legal)
  );

  seg7_to_bcd u_tens_dec (
    .i_pattern (r_tens_pat),
    .o_value   (w_t_val),
    .o_blank   (w_t_blank),
    .o_legal   (w_t_legal)
  );

  assign w_frame_err  = !w_o_legal || !w_t_legal || (w_o_blank && !w_t_blank);
  assign w_both_blank = w_o_blank && w_t_blank;

`ifdef SEG_FRAME_CONFIRM_EN
  // last complete frame; a new frame commits only when it repeats this one
  logic [2*SEG_W-1:0] r_cand;
  logic               r_cand_vld;

  assign w_commit = w_frame && !w_frame_err && r_cand_vld &&
                    (r_cand == {r_tens_pat, r_ones_pat});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand     <= '0;
      r_cand_vld <= 1'b0;
    end else if (w_frame) begin
      if (w_frame_err) begin
        r_cand_vld <= 1'b0;
      end else begin
        r_cand     <= {r_tens_pat, r_ones_pat};
        r_cand_vld <= 1'b1;
      end
    end
  end
`else
  assign w_commit = w_frame && !w_frame_err;
`endif

  // an all-blank display only drops validity; the digits keep their values
  assign w_nxt_valid = !w_both_blank;
  assign w_nxt_tb    = w_both_blank ? r_tens_blank : w_t_blank;
  assign w_nxt_tens  = w_both_blank ? r_score_tens : (w_t_blank ? '0 : w_t_val);
  assign w_nxt_ones  = w_both_blank ? r_score_ones : w_o_val;
  assign w_changed   = {w_nxt_valid, w_nxt_tb, w_nxt_tens, w_nxt_ones} !=
                       {r_score_valid, r_tens_blank, r_score_tens, r_score_ones};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score_valid  <= 1'b0;
      r_score_tens   <= '0;
      r_score_ones   <= '0;
      r_tens_blank   <= 1'b0;
      r_score_update <= 1'b0;
      r_decode_error <= 1'b0;
    end else begin
      r_score_update <= 1'b0;
      r_decode_error <= w_frame && w_frame_err;
      if (w_commit) begin
        r_score_valid  <= w_nxt_valid;
        r_score_tens   <= w_nxt_tens;
        r_score_ones   <= w_nxt_ones;
        r_tens_blank   <= w_nxt_tb;
        r_score_update <= w_changed;
      end else if (w_timeout) begin
        r_score_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_segment_scan_decoder.sv
module tb_segment_scan_decoder;

  localparam int SC = 4;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] segments = '0;
  logic [1:0] segment_digits = '0;
  logic       segments_invert = 1'b0;
  logic       score_valid, tens_blank, score_update, decode_error;
  logic [3:0] score_tens, score_ones;

  int total = 0;
  int bad = 0;
  int n_upd = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  segment_scan_decoder #(.SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .segments        (segments),
    .segment_digits  (segment_digits),
    .segments_invert (segments_invert),
    .score_valid     (score_valid),
    .score_tens      (score_tens),
    .score_ones      (score_ones),
    .tens_blank      (tens_blank),
    .score_update    (score_update),
    .decode_error    (decode_error)
  );

  // 0-9 for digits, 10 for blank, -1 for anything else
  function automatic int seg_val(input logic [6:0] p);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    seg_val = (p == 7'h00) ? 10 : -1;
    for (int i = 0; i < 10; i++) if (tbl[i] == p) seg_val = i;
  endfunction

  // ---------------- behavioural model ----------------
  // A digit is latched when a one-hot strobe has shown the same pattern for
  // SC consecutive samples, at most once per strobe change. Actions on a
  // sample appear one edge after it is taken; a completed frame shows up on
  // the outputs one edge after that.
  logic [1:0] p_sel = '0, pp_sel = '0;
  logic [6:0] p_pat = '0, pp_pat = '0;
  int         run = 0, idle = 0;
  bit         armed = 0, f_ones = 0, f_tens = 0, pend = 0;
  logic [6:0] s_ones = '0, s_tens = '0, pend_o = '0, pend_t = '0;
  logic       m_valid = 0, m_tb = 0, m_upd = 0, m_err = 0;
  logic [3:0] m_tens = '0, m_ones = '0;
`ifdef SEG_FRAME_CONFIRM_EN
  bit         cand_vld = 0;
  logic [13:0] cand = '0;
`endif

  task automatic m_commit(input logic [6:0] po, input logic [6:0] pt);
    int vo, vt;
    bit ok, go;
    logic nv, ntb;
    logic [3:0] nt, no;
    vo = seg_val(po);
    vt = seg_val(pt);
    ok = (vo >= 0) && (vt >= 0) && !(vo == 10 && vt != 10);
    go = ok;
    if (!ok) m_err = 1;
`ifdef SEG_FRAME_CONFIRM_EN
    if (!ok) cand_vld = 0;
    else if (!(cand_vld && cand == {pt, po})) begin
      cand = {pt, po};
      cand_vld = 1;
      go = 0;
    end
`endif
    if (go) begin
      if (vo == 10) begin
        nv = 0; ntb = m_tb; nt = m_tens; no = m_ones;
      end else begin
        nv = 1; ntb = (vt == 10); nt = (vt == 10) ? 4'd0 : 4'(vt); no = 4'(vo);
      end
      m_upd = ({nv, ntb, nt, no} != {m_valid, m_tb, m_tens, m_ones});
      m_valid = nv; m_tb = ntb; m_tens = nt; m_ones = no;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      p_sel = 0; pp_sel = 0; p_pat = 0; pp_pat = 0; run = 0; idle = 0;
      armed = 0; f_ones = 0; f_tens = 0; pend = 0;
      m_valid = 0; m_tb = 0; m_tens = 0; m_ones = 0; m_upd = 0; m_err = 0;
`ifdef SEG_FRAME_CONFIRM_EN
      cand_vld = 0;
`endif
    end else begin
      m_upd = 0;
      m_err = 0;
      if (pend) begin
        m_commit(pend_o, pend_t);
        pend = 0;
      end
      if (p_sel != pp_sel) armed = 1;
      run = ({p_sel, p_pat} == {pp_sel, pp_pat}) ? run + 1 : 1;
      if (p_sel == 2'b01 || p_sel == 2'b10) begin
        idle = 0;
        if (armed && run == SC) begin
          armed = 0;
          if (p_sel == 2'b01) begin s_ones = p_pat; f_ones = 1; end
          else begin s_tens = p_pat; f_tens = 1; end
          if (f_ones && f_tens) begin
            pend = 1; pend_o = s_ones; pend_t = s_tens; f_ones = 0; f_tens = 0;
          end
        end
      end else if (idle < TO) begin
        idle++;
        if (idle == TO) begin m_valid = 0; f_ones = 0; f_tens = 0; end
      end
      pp_sel = p_sel; pp_pat = p_pat;
      p_sel = segment_digits;
      p_pat = segments ^ {7{segments_invert}};
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      total++;
      if ({score_valid, tens_blank, score_tens, score_ones, score_update, decode_error} !==
          {m_valid, m_tb, m_tens, m_ones, m_upd, m_err}) begin
        bad++;
        $display("FAIL cycle t=%0t got v=%b tb=%b %0d%0d upd=%b err=%b want v=%b tb=%b %0d%0d upd=%b err=%b",
                 $time, score_valid, tens_blank, score_tens, score_ones, score_update, decode_error,
                 m_valid, m_tb, m_tens, m_ones, m_upd, m_err);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (score_update === 1'b1) n_upd++;
    if (decode_error === 1'b1) n_err++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [6:0] pat, input int n);
    segment_digits = sel;
    segments = pat ^ {7{segments_invert}};
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [6:0] o, input logic [6:0] t);
    drive(2'b01, o, 10);
    drive(2'b10, t, 10);
    drive(2'b00, 7'h00, 4);
  endtask

  // a frame that is guaranteed to commit in either build
  task automatic cframe(input logic [6:0] o, input logic [6:0] t);
    frame(o, t);
`ifdef SEG_FRAME_CONFIRM_EN
    frame(o, t);
`endif
  endtask

  task automatic check_score(input string name, input int v, input int t, input int o, input int tb);
    check({name, "_valid"}, 32'(score_valid), 32'(v));
    check({name, "_tens"}, 32'(score_tens), 32'(t));
    check({name, "_ones"}, 32'(score_ones), 32'(o));
    check({name, "_tblank"}, 32'(tens_blank), 32'(tb));
  endtask

  initial begin
    int u0, e0, k_fall;
    repeat (3) @(negedge clk);
    check_score("reset", 0, 0, 0, 0);
    check("reset_upd", 32'(score_update), 0);
    check("reset_err", 32'(decode_error), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 13 from ones=4F, tens=06
    u0 = n_upd;
    cframe(7'h4F, 7'h06);
    check_score("score13", 1, 1, 3, 0);
    check("score13_pulses", 32'(n_upd - u0), 1);

    // inverted bus, ones=5, tens blank
    segments_invert = 1'b1;
    cframe(7'h6D, 7'h00);
    check_score("inv5", 1, 0, 5, 1);
    segments_invert = 1'b0;

    // illegal ones pattern
    u0 = n_upd; e0 = n_err;
    frame(7'h49, 7'h06);
    check("illegal_err", 32'(n_err - e0), 1);
    check("illegal_upd", 32'(n_upd - u0), 0);
    check_score("illegal_hold", 1, 0, 5, 1);

    // glitching pattern never settles, then a stable frame 12
    u0 = n_upd;
    for (int i = 0; i < 6; i++) drive(2'b01, (i % 2) ? 7'h06 : 7'h3F, 3);
    check("glitch_upd", 32'(n_upd - u0), 0);
    drive(2'b01, 7'h5B, 10);
    drive(2'b10, 7'h06, 10);
    drive(2'b00, 7'h00, 4);
`ifdef SEG_FRAME_CONFIRM_EN
    frame(7'h5B, 7'h06);
`endif
    check_score("score12", 1, 1, 2, 0);

    // frames 21, 37, 37
    frame(7'h06, 7'h5B);
`ifdef SEG_FRAME_CONFIRM_EN
    check_score("f21", 1, 1, 2, 0);
`else
    check_score("f21", 1, 2, 1, 0);
`endif
    frame(7'h07, 7'h4F);
`ifdef SEG_FRAME_CONFIRM_EN
    check_score("f37a", 1, 1, 2, 0);
`else
    check_score("f37a", 1, 3, 7, 0);
`endif
    frame(7'h07, 7'h4F);
    check_score("f37b", 1, 3, 7, 0);

    // both blank: invalid, digits kept, no error
    u0 = n_upd; e0 = n_err;
    cframe(7'h00, 7'h00);
    check_score("blank", 0, 3, 7, 0);
    check("blank_err", 32'(n_err - e0), 0);
    check("blank_upd", 32'(n_upd - u0), 1);

    // timeout: valid drops TO idle cycles after the registered strobe goes idle
    cframe(7'h4F, 7'h06);
    check_score("pre_to", 1, 1, 3, 0);
    drive(2'b01, 7'h06, 2);
    segment_digits = 2'b00;
    k_fall = 0;
    for (int k = 1; k <= 3 * TO && k_fall == 0; k++) begin
      @(posedge clk);
      #1;
      if (!score_valid) k_fall = k;
    end
    check("timeout_edges", 32'(k_fall), 32'(TO + 1));
    @(negedge clk);

    // reset in the middle of a frame
    cframe(7'h4F, 7'h06);
    drive(2'b01, 7'h66, 10);
    #2 rst_n = 1'b0;
    #1;
    check_score("midrst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    u0 = n_upd;
    drive(2'b10, 7'h06, 10);
    drive(2'b00, 7'h00, 4);
    check("midrst_nocommit", 32'(n_upd - u0), 0);
    check("midrst_invalid", 32'(score_valid), 0);
    cframe(7'h4F, 7'h06);
    check_score("post_rst", 1, 1, 3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
